// File: rtl/mem_data_arbiter.sv
// Two-port round-robin arbiter/sequencer in front of Memory_Data.
// One transaction at a time: IDLE -> ACCESS -> DONE, three cycles each.
module mem_data_arbiter #(
  parameter int ADDR_W = 21,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              gnt0,
  output logic              done0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt1,
  output logic              done1,
  output logic [DATA_W-1:0] rdata,
  output logic [DATA_W-1:0] Mdst,
  output logic [ADDR_W-1:0] Mdst_addr,
  output logic [ADDR_W-1:0] Msrc1_addr,
  output logic              Mwrite,
  input  logic [DATA_W-1:0] Msrc1
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } cmd_t;

  state_t state;
  cmd_t   cmd, req_cmd;
  logic   owner, prio, sel, wr_q;

  // A lone requester wins outright; the pointer only breaks ties.
  always_comb begin
    sel     = (req0 && req1) ? prio : req1;
    req_cmd = sel ? cmd_t'{we1, addr1, wdata1} : cmd_t'{we0, addr0, wdata0};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      prio  <= 1'b0;
      owner <= 1'b0;
      cmd   <= '0;
      rdata <= '0;
      gnt0  <= 1'b0;
      gnt1  <= 1'b0;
      done0 <= 1'b0;
      done1 <= 1'b0;
      wr_q  <= 1'b0;
    end else begin
      gnt0  <= 1'b0;
      gnt1  <= 1'b0;
      done0 <= 1'b0;
      done1 <= 1'b0;
      wr_q  <= 1'b0;
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            owner <= sel;
            cmd   <= req_cmd;
            gnt0  <= ~sel;
            gnt1  <= sel;
            wr_q  <= req_cmd.we;
            state <= ACCESS;
          end
        end
        ACCESS: begin
          if (!cmd.we) rdata <= Msrc1;
          prio  <= ~owner;
          done0 <= ~owner;
          done1 <= owner;
          state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Memory side holds the last command between transactions.
  assign Mdst       = cmd.wdata;
  assign Mdst_addr  = cmd.addr;
  assign Msrc1_addr = cmd.addr;
  // Gated by rst so a write in flight is killed in the same cycle.
  assign Mwrite     = wr_q & ~rst;

endmodule

// File: tb/tb_mem_data_arbiter.sv
// Bench for mem_data_arbiter: per-port drivers, done-driven scoreboard,
// grant log for ordering/spacing, behavioural Memory_Data model.
module tb_mem_data_arbiter;
  localparam int AW = 21;
  localparam int DW = 16;

  logic clk = 1'b0, rst = 1'b1;
  logic req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [DW-1:0] wdata0 = '0, wdata1 = '0;
  logic gnt0, done0, gnt1, done1, Mwrite;
  logic [DW-1:0] rdata, Mdst, Msrc1;
  logic [AW-1:0] Mdst_addr, Msrc1_addr;
  logic [DW-1:0] mem [0:255];

  typedef struct {
    int            grp;
    bit            port;
    bit            we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] exp_rd;
  } vec_t;

  typedef struct {
    bit port;
    int cyc;
  } gnt_t;

  vec_t tbl[$];
  vec_t q0[$], q1[$], e0[$], e1[$];
  gnt_t glog[$];
  int   n_cmp = 0, n_err = 0;
  int   cyc = 0, last_g0 = 0, last_g1 = 0, wr_cnt = 0;
  logic [DW-1:0] model_rd = '0;

  mem_data_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .gnt0(gnt0), .done0(done0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .gnt1(gnt1), .done1(done1),
    .rdata(rdata), .Mdst(Mdst), .Mdst_addr(Mdst_addr), .Msrc1_addr(Msrc1_addr),
    .Mwrite(Mwrite), .Msrc1(Msrc1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory_Data model: write commits on the rising edge, read is combinational.
  initial for (int i = 0; i < 256; i++) mem[i] <= 16'hA000 + 16'(i);
  always @(posedge clk) if (Mwrite) mem[Mdst_addr[7:0]] <= Mdst;
  assign Msrc1 = mem[Msrc1_addr[7:0]];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void add(int g, bit p, bit w, int a, int d, int e);
    vec_t v;
    v.grp = g; v.port = p; v.we = w;
    v.addr = AW'(a); v.wdata = DW'(d); v.exp_rd = DW'(e);
    tbl.push_back(v);
  endfunction

  task automatic run_grp(input int g);
    for (int i = 0; i < tbl.size(); i++)
      if (tbl[i].grp == g) begin
        if (tbl[i].port) q1.push_back(tbl[i]);
        else             q0.push_back(tbl[i]);
      end
  endtask

  task automatic drain(input string name, input int budget);
    int n = 0;
    while ((q0.size() + q1.size() + e0.size() + e1.size()) != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_drain"}, 32'(n < budget), 32'd1);
    repeat (2) @(negedge clk);
  endtask

  task automatic chk_order(input string name, input int n, input int first, input bit alt);
    chk({name, "_ngnt"}, 32'(glog.size()), 32'(n));
    for (int i = 0; i < n && i < glog.size(); i++) begin
      chk({name, "_port"}, 32'(glog[i].port), 32'(alt ? (first + i) % 2 : first));
      if (i > 0) chk({name, "_spacing"}, 32'(glog[i].cyc - glog[i-1].cyc), 32'd3);
    end
    glog.delete();
  endtask

  // Requesters: hold req until the grant is seen, then move straight to the next command.
  initial begin : drv0
    vec_t v;
    forever begin
      @(negedge clk);
      if (gnt0) req0 = 1'b0;
      if (!req0 && q0.size() > 0) begin
        v = q0.pop_front();
        e0.push_back(v);
        req0 = 1'b1; we0 = v.we; addr0 = v.addr; wdata0 = v.wdata;
      end
    end
  end

  initial begin : drv1
    vec_t v;
    forever begin
      @(negedge clk);
      if (gnt1) req1 = 1'b0;
      if (!req1 && q1.size() > 0) begin
        v = q1.pop_front();
        e1.push_back(v);
        req1 = 1'b1; we1 = v.we; addr1 = v.addr; wdata1 = v.wdata;
      end
    end
  end

  // Scoreboard: each done pops that port's oldest issued command.
  always @(negedge clk) begin : mon
    vec_t v;
    if (gnt0 || gnt1) begin
      chk("gnt_excl", 32'(gnt0 & gnt1), 32'd0);
      glog.push_back(gnt_t'{gnt1, cyc});
      if (gnt0) last_g0 = cyc; else last_g1 = cyc;
    end
    if (Mwrite) begin
      wr_cnt++;
      chk("mwrite_in_access", 32'(gnt0 | gnt1), 32'd1);
    end
    if (done0 || done1) chk("done_excl", 32'(done0 & done1), 32'd0);
    if (done0) begin
      if (e0.size() == 0) chk("done0_unexpected", 32'd1, 32'd0);
      else begin
        v = e0.pop_front();
        chk("done0_latency", 32'(cyc - last_g0), 32'd1);
        if (!v.we) model_rd = v.exp_rd;
        chk("done0_rdata", 32'(rdata), 32'(model_rd));
      end
    end
    if (done1) begin
      if (e1.size() == 0) chk("done1_unexpected", 32'd1, 32'd0);
      else begin
        v = e1.pop_front();
        chk("done1_latency", 32'(cyc - last_g1), 32'd1);
        if (!v.we) model_rd = v.exp_rd;
        chk("done1_rdata", 32'(rdata), 32'(model_rd));
      end
    end
  end

  initial begin : main
    int w0, n;
    // grp, port, we, addr, wdata, expected read data
    add(1, 0, 1, 8, 16'h0123, 0);   add(1, 1, 1, 9, 16'h0456, 0);
    add(2, 0, 1, 1, 47, 0);         add(2, 0, 0, 1, 0, 47);
    for (int i = 0; i < 3; i++) begin add(3, 0, 1, 2, 74, 0); add(3, 1, 1, 3, 99, 0); end
    for (int i = 0; i < 3; i++) add(4, 1, 0, 3, 0, 99);
    add(5, 1, 1, 5, 55, 0);
    add(6, 1, 0, 5, 0, 16'hA005);
    add(7, 0, 0, 2, 0, 74);         add(7, 0, 0, 2, 0, 11);   add(7, 1, 1, 2, 11, 0);

    // Reset held two cycles with requests pending.
    rst = 1'b1;
    run_grp(1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_gnt",   32'({gnt0, gnt1}), 32'd0);
    chk("rst_done",  32'({done0, done1}), 32'd0);
    chk("rst_mwrite", 32'(Mwrite), 32'd0);
    chk("rst_rdata", 32'(rdata), 32'd0);
    chk("rst_addr",  32'(Mdst_addr | Msrc1_addr), 32'd0);
    chk("rst_mdst",  32'(Mdst), 32'd0);
    rst = 1'b0;
    drain("t1", 40);
    chk_order("t1", 2, 0, 1'b1);

    // Port 0 write then read-back.
    @(posedge clk); #1;
    w0 = wr_cnt;
    run_grp(2);
    drain("t2", 40);
    chk("t2_writes", 32'(wr_cnt - w0), 32'd1);
    chk_order("t2", 2, 0, 1'b0);

    // Both ports streaming writes: strict alternation, pointer left at port 1.
    @(posedge clk); #1;
    w0 = wr_cnt;
    run_grp(3);
    drain("t3", 80);
    chk("t3_writes", 32'(wr_cnt - w0), 32'd6);
    chk("t3_mem2", 32'(mem[2]), 32'd74);
    chk("t3_mem3", 32'(mem[3]), 32'd99);
    chk_order("t3", 6, 1, 1'b1);

    // Port 1 alone.
    @(posedge clk); #1;
    run_grp(4);
    drain("t4", 60);
    chk_order("t4", 3, 1, 1'b0);

    // Reset lands in the ACCESS cycle of a port 1 write.
    @(posedge clk); #1;
    run_grp(5);
    n = 0;
    do begin @(negedge clk); n++; end while (!gnt1 && n < 20);
    chk("t5_gnt1", 32'(gnt1), 32'd1);
    rst = 1'b1;
    #1;
    chk("t5_mwrite_gated", 32'(Mwrite), 32'd0);
    @(negedge clk);
    chk("t5_no_done", 32'({done0, done1}), 32'd0);
    chk("t5_gnt_clr", 32'({gnt0, gnt1}), 32'd0);
    chk("t5_addr_clr", 32'(Mdst_addr), 32'd0);
    chk("t5_rdata_clr", 32'(rdata), 32'd0);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("t5_dropped", 32'(e1.size()), 32'd1);
    e1.delete();
    glog.delete();
    model_rd = '0;

    @(posedge clk); #1;
    run_grp(6);
    drain("t6", 40);
    chk_order("t6", 1, 1, 1'b0);

    // Read granted ahead of a conflicting write, then read sees the new data.
    @(posedge clk); #1;
    run_grp(7);
    drain("t7", 60);
    chk_order("t7", 3, 0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: bench did not complete, %0d compared", n_cmp);
    $fatal(1, "timeout");
  end

endmodule
